uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready holding register, framing-error and overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 majority voting at each sample point.
module uart_rx #(
    parameter int CLK_FREQ = 16_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic              rx_meta_r;
    logic              rx_sync_r;
    logic              rx_prev_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic [7:0]        data_r;
    logic              valid_r;
    logic              frame_err_r;
    logic              overrun_r;

    logic              fall_s;
    logic              active_s;
    logic              tick_s;
    logic              sample_s;
    logic              load_half_s;
    logic              enter_data_s;
    logic              shift_en_s;
    logic              deliver_s;
    logic              frame_err_s;
    logic              accept_s;

    assign fall_s   = rx_prev_r & ~rx_sync_r;
    assign active_s = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);
    assign accept_s = valid_r & i_ready;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic vote_a_r;
    logic vote_b_r;
    logic pend_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the two early votes; the decision is taken one cycle later with the third.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vote_a_r <= 1'b1;
            vote_b_r <= 1'b1;
            pend_r   <= 1'b0;
        end else begin
            if (active_s && (cnt_r == CNT_ONE)) begin
                vote_a_r <= rx_sync_r;
            end
            if (active_s && (cnt_r == CNT_ZERO)) begin
                vote_b_r <= rx_sync_r;
            end
            pend_r <= active_s && (cnt_r == CNT_ZERO);
        end
    end

    assign tick_s   = pend_r;
    assign sample_s = maj3(vote_a_r, vote_b_r, rx_sync_r);
`else
    assign tick_s   = active_s && (cnt_r == CNT_ZERO);
    assign sample_s = rx_sync_r;
`endif

    // Two-flop synchroniser plus delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        state_nx_s   = state_r;
        load_half_s  = 1'b0;
        enter_data_s = 1'b0;
        shift_en_s   = 1'b0;
        deliver_s    = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nx_s  = ST_START;
                    load_half_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (sample_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s   = ST_DATA;
                        enter_data_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_en_s = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (sample_s) begin
                        deliver_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_nx_s  = ST_WAIT_HIGH;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_sync_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Baud counter: half-bit load on start edge, then free-running DIV reloads while in a frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load_half_s) begin
            cnt_r <= CNT_HALF_M1;
        end else if (active_s) begin
            cnt_r <= (cnt_r == CNT_ZERO) ? CNT_DIV_M1 : (cnt_r - CNT_W'(1));
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else if (enter_data_s) begin
            bit_idx_r <= 3'd0;
        end else if (shift_en_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            shift_r   <= {sample_s, shift_r[7:1]};
        end else begin
            bit_idx_r <= bit_idx_r;
        end
    end

    // Holding register, handshake and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_r      <= 8'd0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= frame_err_s;
            overrun_r   <= 1'b0;
            if (deliver_s) begin
                if (!valid_r || accept_s) begin
                    data_r  <= shift_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (accept_s) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes popped on each accepted output.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DIV_TB  = 138;
    localparam int HALF_TB = 69;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_TB  = HALF_TB + 9 * DIV_TB + 2;
`else
    localparam int LAT_TB  = HALF_TB + 9 * DIV_TB + 1;
`endif

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    int         n_checks;
    int         n_pass;
    int         cyc;
    int         tx_start_cyc;
    int         rise_cnt;
    int         last_rise_cyc;
    int         ferr_cnt;
    int         ovr_cnt;
    logic       valid_d;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(16_000_000), .BAUD(115_200)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun(o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted byte and tallies pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_valid && !valid_d) begin
                rise_cnt++;
                last_rise_cyc = cyc;
            end
            if (o_frame_err) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("unexpected_byte", 32'(o_data), 32'hFFFF_FFFF);
                end else begin
                    check_value("rx_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
        end
        valid_d = o_valid;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int glitch_at);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int t = 0; t < 10 * DIV_TB; t++) begin
            @(posedge clk); #1;
            if (t == 0) tx_start_cyc = cyc;
            rx = frame[t / DIV_TB] ^ (t == glitch_at);
        end
    endtask

    initial begin
        int r0, f0, o0;
        n_checks = 0; n_pass = 0; cyc = 0;
        rise_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; last_rise_cyc = 0; tx_start_cyc = 0;
        valid_d = 1'b0;
        rx = 1'b1; i_ready = 1'b0; reset_n = 1'b0;
        idle(4);
        reset_n = 1'b1;
        @(negedge clk);
        check_value("reset_valid", 32'(o_valid), 32'd0);
        check_value("reset_data", 32'(o_data), 32'd0);
        check_value("reset_ferr", 32'(o_frame_err), 32'd0);
        check_value("reset_ovr", 32'(o_overrun), 32'd0);
        idle(DIV_TB);

        // Basic frame with latency measurement.
        i_ready = 1'b1;
        r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h58);
        send_byte(8'h58, 1'b1, -1);
        idle(DIV_TB);
        check_value("x_rises", 32'(rise_cnt - r0), 32'd1);
        check_value("x_latency", 32'(last_rise_cyc - tx_start_cyc), 32'(2 + LAT_TB));
        check_value("x_errs", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

        // Overrun: two frames with no drain.
        i_ready = 1'b0;
        r0 = rise_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h31);
        send_byte(8'h31, 1'b1, -1);
        send_byte(8'h32, 1'b1, -1);
        idle(20);
        check_value("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check_value("ovr_valid", 32'(o_valid), 32'd1);
        check_value("ovr_hold_data", 32'(o_data), 32'h31);
        i_ready = 1'b1;
        idle(DIV_TB);
        check_value("ovr_rises", 32'(rise_cnt - r0), 32'd1);
        check_value("ovr_drained", 32'(o_valid), 32'd0);

        // Framing error, break, then recovery.
        r0 = rise_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b0, -1);
        idle(3 * DIV_TB);
        rx = 1'b1;
        idle(2 * DIV_TB);
        check_value("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check_value("ferr_no_valid", 32'(rise_cnt - r0), 32'd0);
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1, -1);
        idle(DIV_TB);
        check_value("ferr_recover", 32'(rise_cnt - r0), 32'd1);

        // False start glitch.
        r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(2 * DIV_TB);
        check_value("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
        check_value("glitch_no_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
        exp_q.push_back(8'h0D);
        send_byte(8'h0D, 1'b1, -1);
        idle(DIV_TB);
        check_value("glitch_recover", 32'(rise_cnt - r0), 32'd1);

        // Reset in the middle of data bit 4.
        r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        fork
            send_byte(8'hFF, 1'b1, -1);
            begin
                idle(5 * DIV_TB + 60);
                reset_n = 1'b0;
                idle(1);
                reset_n = 1'b1;
                @(negedge clk);
                check_value("rst_mid_valid", 32'(o_valid), 32'd0);
                check_value("rst_mid_data", 32'(o_data), 32'd0);
            end
        join
        idle(DIV_TB);
        check_value("rst_mid_quiet", 32'(rise_cnt - r0 + ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
        exp_q.push_back(8'h0A);
        send_byte(8'h0A, 1'b1, -1);
        idle(DIV_TB);
        check_value("rst_recover", 32'(rise_cnt - r0), 32'd1);

        // One-cycle inversion at the data bit 2 sample point.
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h55);
`else
        exp_q.push_back(8'h51);
`endif
        r0 = rise_cnt;
        send_byte(8'h55, 1'b1, HALF_TB + 3 * DIV_TB);
        idle(DIV_TB);
        check_value("spike_rises", 32'(rise_cnt - r0), 32'd1);
        check_value("spike_latency", 32'(last_rise_cyc - tx_start_cyc), 32'(2 + LAT_TB));

        check_value("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
